// File: rtl/instr_sequencer.sv
// Multi-cycle RV32I instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control, shared memory port,
// wait-state timeout and illegal-opcode faulting. Define SEQ_PERF_CNT_EN for a live retired_cnt.
module instr_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        mem_err,
    input  logic        fault_clr,
    output logic        mem_req,
    output logic        mem_write,
    output logic        mem_data_sel,
    output logic        ir_we,
    output logic        dec_en,
    output logic        pc_we,
    output logic        rf_we,
    output logic        busy,
    output logic        fault,
    output logic [2:0]  state,
    output logic [31:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6,
        S_UNUSED = 3'd7
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     cur;
    logic [7:0] wait_cnt;
    logic       is_store;

    logic op_mem, op_branch, op_wb;
    logic xfer_err, xfer_done, xfer_timeout;
    state_t after_retire;

    always_comb begin
        op_mem    = 1'b0;
        op_branch = 1'b0;
        op_wb     = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE: op_mem = 1'b1;
            OP_BRANCH:         op_branch = 1'b1;
            OP_REG, OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_wb = 1'b1;
            default: ;
        endcase
    end

    // Response priority within one cycle: error, then ready, then timeout.
    assign xfer_err     = mem_req && mem_err;
    assign xfer_done    = mem_req && mem_ready && !mem_err;
    assign xfer_timeout = mem_req && !mem_err && !mem_ready && (wait_cnt == TIMER_LAST);

    assign after_retire = run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= S_IDLE;
            wait_cnt <= 8'd0;
            is_store <= 1'b0;
        end else begin
            case (cur)
                S_IDLE: begin
                    if (run) begin
                        cur      <= S_FETCH;
                        wait_cnt <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (xfer_err) begin
                        cur <= S_FAULT;
                    end else if (xfer_done) begin
                        cur <= S_DECODE;
                    end else if (xfer_timeout) begin
                        cur <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: cur <= S_EXEC;
                S_EXEC: begin
                    if (op_mem) begin
                        cur      <= S_MEM;
                        wait_cnt <= 8'd0;
                        is_store <= (opcode == OP_STORE);
                    end else if (op_branch) begin
                        cur      <= after_retire;
                        wait_cnt <= 8'd0;
                    end else if (op_wb) begin
                        cur <= S_WB;
                    end else begin
                        cur <= S_FAULT;
                    end
                end
                S_MEM: begin
                    if (xfer_err) begin
                        cur <= S_FAULT;
                    end else if (xfer_done) begin
                        cur      <= is_store ? after_retire : S_WB;
                        wait_cnt <= 8'd0;
                    end else if (xfer_timeout) begin
                        cur <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    cur      <= after_retire;
                    wait_cnt <= 8'd0;
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        cur <= S_IDLE;
                    end
                end
                default: cur <= S_IDLE;
            endcase
        end
    end

    // Moore outputs come straight off the state register, so reset drops them immediately.
    assign mem_req      = (cur == S_FETCH) || (cur == S_MEM);
    assign mem_data_sel = (cur == S_MEM);
    assign mem_write    = (cur == S_MEM) && is_store;
    assign dec_en       = (cur == S_DECODE);
    assign rf_we        = (cur == S_WB);
    assign busy         = (cur != S_IDLE) && (cur != S_FAULT);
    assign fault        = (cur == S_FAULT);
    assign state        = cur;

    assign ir_we = (cur == S_FETCH) && xfer_done;
    assign pc_we = ((cur == S_EXEC) && op_branch)
                || ((cur == S_MEM) && is_store && xfer_done)
                || (cur == S_WB);

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= 32'd0;
        end else if (pc_we) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
`else
    assign retired_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios then random instruction streams, each expanded
// into a per-cycle expected schedule from the phase/latency rules of the sequencer.
module tb_instr_sequencer;

    localparam int TO = 4;
`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        run;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        mem_err;
    logic        fault_clr;
    logic        mem_req, mem_write, mem_data_sel, ir_we, dec_en, pc_we, rf_we, busy, fault;
    logic [2:0]  state;
    logic [31:0] retired_cnt;

    instr_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode),
        .mem_ready(mem_ready), .mem_err(mem_err), .fault_clr(fault_clr),
        .mem_req(mem_req), .mem_write(mem_write), .mem_data_sel(mem_data_sel),
        .ir_we(ir_we), .dec_en(dec_en), .pc_we(pc_we), .rf_we(rf_we),
        .busy(busy), .fault(fault), .state(state), .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One scheduled cycle: inputs to drive plus the outputs expected in that cycle.
    typedef struct packed {
        logic       run, rdy, err, clr;
        logic [2:0] st;
        logic       req, wr, sel, ir, dec, pc, rf;
    } cyc_t;

    cyc_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] model_ret = 32'd0;
    bit          need_idle;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(bit r, bit rdy, bit err, bit clr, logic [2:0] st,
                                 bit req, bit wr, bit sel, bit ir, bit dec, bit pc, bit rf);
        cyc_t c;
        c = '{run: r, rdy: rdy, err: err, clr: clr, st: st, req: req, wr: wr, sel: sel,
              ir: ir, dec: dec, pc: pc, rf: rf};
        exp_q.push_back(c);
    endfunction

    // 0 branch, 1 writeback class, 2 load, 3 store, 4 illegal
    function automatic int op_class(logic [6:0] op);
        case (op)
            7'b1100011: return 0;
            7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1;
            7'b0000011: return 2;
            7'b0100011: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic void fault_seq();
        int n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) push(rb(), rb(), rb(), 1'b0, 3'd6, 0, 0, 0, 0, 0, 0, 0);
        push(rb(), rb(), rb(), 1'b1, 3'd6, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Wait cycles of a transfer; returns 1 if the transfer ended in FAULT (schedule already pushed).
    function automatic bit transfer(logic [2:0] st, int w, bit e, bit e_rdy, bit wr, bit sel);
        if (w >= TO) begin
            for (int i = 0; i < TO; i++) push(rb(), 1'b0, 1'b0, rb(), st, 1, wr, sel, 0, 0, 0, 0);
            fault_seq();
            return 1'b1;
        end
        for (int i = 0; i < w; i++) push(rb(), 1'b0, 1'b0, rb(), st, 1, wr, sel, 0, 0, 0, 0);
        if (e) begin
            push(rb(), e_rdy, 1'b1, rb(), st, 1, wr, sel, 0, 0, 0, 0);
            fault_seq();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Schedules one instruction; returns 1 if the next one must start from IDLE.
    function automatic bit build_instr(logic [6:0] op, int wf, bit ferr, int wm, bit merr,
                                       bit e_rdy, bit run_next, bit lead);
        int k = op_class(op);
        if (lead) push(1'b1, rb(), rb(), 1'b0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        if (transfer(3'd1, wf, ferr, e_rdy, 1'b0, 1'b0)) return 1'b1;
        push(rb(), 1'b1, 1'b0, rb(), 3'd1, 1, 0, 0, 1, 0, 0, 0);
        push(rb(), rb(), rb(), rb(), 3'd2, 0, 0, 0, 0, 1, 0, 0);
        if (k == 0) begin
            push(run_next, rb(), rb(), rb(), 3'd3, 0, 0, 0, 0, 0, 1, 0);
            return !run_next;
        end
        if (k == 4) begin
            push(rb(), rb(), rb(), rb(), 3'd3, 0, 0, 0, 0, 0, 0, 0);
            fault_seq();
            return 1'b1;
        end
        push(rb(), rb(), rb(), rb(), 3'd3, 0, 0, 0, 0, 0, 0, 0);
        if (k == 2 || k == 3) begin
            if (transfer(3'd4, wm, merr, e_rdy, k == 3, 1'b1)) return 1'b1;
            if (k == 3) begin
                push(run_next, 1'b1, 1'b0, rb(), 3'd4, 1, 1, 1, 0, 0, 1, 0);
                return !run_next;
            end
            push(rb(), 1'b1, 1'b0, rb(), 3'd4, 1, 0, 1, 0, 0, 0, 0);
        end
        push(run_next, rb(), rb(), rb(), 3'd5, 0, 0, 0, 0, 0, 1, 1);
        return !run_next;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [11:0] outs_vec();
        return {state, busy, fault, mem_req, mem_write, mem_data_sel, ir_we, dec_en, pc_we, rf_we};
    endfunction

    // Called at posedge+1; drives inputs, samples mid-cycle, returns at next posedge+1.
    task automatic step(input cyc_t c, input logic [6:0] op);
        logic [11:0] e;
        run = c.run; mem_ready = c.rdy; mem_err = c.err; fault_clr = c.clr; opcode = op;
        #4;
        e = {c.st, (c.st != 3'd0 && c.st != 3'd6), (c.st == 3'd6),
             c.req, c.wr, c.sel, c.ir, c.dec, c.pc, c.rf};
        check("outs", 32'(outs_vec()), 32'(e));
        check("retired_cnt", retired_cnt, PERF ? model_ret : 32'd0);
        if (c.pc) model_ret = model_ret + 32'd1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_sched(input logic [6:0] op, input int max_cycles);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            step(exp_q.pop_front(), op);
            n++;
        end
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] legal [9];
        legal = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        if ($urandom_range(0, 99) < 85) return legal[$urandom_range(0, 8)];
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic int rand_wait();
        if ($urandom_range(0, 99) < 10) return TO;
        return $urandom_range(0, TO - 1);
    endfunction

    initial begin
        reset = 1'b1; run = 1'b0; opcode = 7'd0; mem_ready = 1'b0; mem_err = 1'b0; fault_clr = 1'b0;
        #2;
        check("reset_outs", 32'(outs_vec()), 32'd0);
        check("reset_retired", retired_cnt, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // R-type, zero wait, back-to-back into a second R-type
        need_idle = build_instr(7'b0110011, 0, 0, 0, 0, 1, 1, 1);
        run_sched(7'b0110011, 1000);
        need_idle = build_instr(7'b0110011, 0, 0, 0, 0, 1, 0, need_idle);
        run_sched(7'b0110011, 1000);
        // load with three MEM wait cycles
        need_idle = build_instr(7'b0000011, 0, 0, 3, 0, 1, 0, need_idle);
        run_sched(7'b0000011, 1000);
        // store, then IDLE with run low
        need_idle = build_instr(7'b0100011, 1, 0, 0, 0, 1, 0, need_idle);
        run_sched(7'b0100011, 1000);
        push(1'b0, rb(), rb(), 1'b0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        run_sched(7'b0100011, 1000);
        // branch back-to-back
        need_idle = build_instr(7'b1100011, 2, 0, 0, 0, 1, 1, need_idle);
        run_sched(7'b1100011, 1000);
        // FETCH timeout
        need_idle = build_instr(7'b0110011, TO, 0, 0, 0, 1, 1, need_idle);
        run_sched(7'b0110011, 1000);
        // illegal opcode
        need_idle = build_instr(7'b1111111, 0, 0, 0, 0, 1, 1, need_idle);
        run_sched(7'b1111111, 1000);
        // mem_err together with mem_ready in MEM
        need_idle = build_instr(7'b0000011, 0, 0, 1, 1, 1, 1, need_idle);
        run_sched(7'b0000011, 1000);

        // reset in the middle of a MEM transfer
        need_idle = build_instr(7'b0000011, 0, 0, 3, 0, 1, 1, need_idle);
        run_sched(7'b0000011, 4 + (need_idle ? 1 : 0));
        mem_ready = 1'b0; mem_err = 1'b0;
        #2;
        check("pre_reset_state", 32'(state), 32'd4);
        check("pre_reset_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_req", 32'(mem_req), 32'd0);
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_retired", retired_cnt, 32'd0);
        exp_q.delete();
        model_ret = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        need_idle = 1'b1;

        // random instruction stream
        for (int i = 0; i < 70; i++) begin
            logic [6:0] op = rand_op();
            int extra = $urandom_range(0, 99) < 20 ? $urandom_range(1, 2) : 0;
            if (need_idle) begin
                for (int j = 0; j < extra; j++) push(1'b0, rb(), rb(), rb(), 3'd0, 0, 0, 0, 0, 0, 0, 0);
            end
            need_idle = build_instr(op, rand_wait(), $urandom_range(0, 99) < 8, rand_wait(),
                                    $urandom_range(0, 99) < 8, rb(), rb(), need_idle);
            run_sched(op, 1000);
        end
        #4;
        check("final_retired", retired_cnt, PERF ? model_ret : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the RV32I core: steps each instruction through fetch, decode, execute, memory and writeback, and owns the single shared memory port. It strobes the instruction register, PC, register file and the registered opcode decoder, which captures on the DECODE cycle. It also handles memory wait states, timeouts and illegal opcodes.

## Interface
- `TIMEOUT_CYC`, default 16: maximum consecutive cycles a memory request may wait for `mem_ready` (legal range 2..255).
- `clk` in 1: core clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `run` in 1: level; allows a new instruction to start from IDLE or after retirement.
- `opcode` in 7: `instr[6:0]` from the instruction register; stable from DECODE onward.
- `mem_ready` in 1: transfer completes in any cycle with `mem_req && mem_ready`.
- `mem_err` in 1: error response; sampled only while `mem_req`=1.
- `fault_clr` in 1: leaves FAULT.
- `mem_req` out 1: memory request.
- `mem_write` out 1: 1 = store.
- `mem_data_sel` out 1: address source, 0 = PC, 1 = ALU result.
- `ir_we` out 1: instruction register load.
- `dec_en` out 1: decoder capture cycle.
- `pc_we` out 1: PC update, asserted exactly once per retired instruction.
- `rf_we` out 1: register file write.
- `busy` out 1: state is neither IDLE nor FAULT.
- `fault` out 1: state is FAULT.
- `state` out 3: current state encoding.
- `retired_cnt` out 32: retired-instruction count.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6. Encoding 7 is unreachable and returns to IDLE.
- IDLE: if `run`=1, go to FETCH.
- FETCH: `mem_req`=1, `mem_data_sel`=0, `mem_write`=0.
  - `mem_err`: go to FAULT.
  - Else `mem_ready`: `ir_we`=1 in that cycle, go to DECODE.
  - Else timeout: go to FAULT.
- DECODE: `dec_en`=1 for one cycle, go to EXEC.
- EXEC: one cycle; next state by `opcode`.
  - Load 0000011 or store 0100011: go to MEM.
  - Branch 1100011: `pc_we`=1 (retire), go to FETCH if `run` else IDLE.
  - R-type 0110011, I-type 0010011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111: go to WB.
  - Any other opcode: go to FAULT; no `pc_we` or `rf_we`.
- MEM: `mem_req`=1, `mem_data_sel`=1, `mem_write`=1 only for store. Error and timeout handling are as in FETCH.
  - On `mem_ready` for a load: go to WB.
  - On `mem_ready` for a store: `pc_we`=1 in that cycle (retire), go to FETCH if `run` else IDLE.
- WB: `rf_we`=1, `pc_we`=1 (retire), go to FETCH if `run` else IDLE.
- FAULT: all strobes 0, `fault`=1; sticky until `fault_clr`=1, which goes to IDLE.
- Output types:
  - Moore, decoded from `state`: `mem_req`, `mem_write`, `mem_data_sel`, `dec_en`, `rf_we`, `busy`, `fault`.
  - Mealy, qualified by `mem_ready` or `opcode`: `ir_we`, `pc_we` in the EXEC and MEM cases.
- Wait timer: 8-bit.
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle in FETCH/MEM with `mem_ready`=0.
  - Timeout = `mem_ready`=0 while timer = `TIMEOUT_CYC`-1.
  - Priority in the same cycle: `mem_err` > `mem_ready` > timeout.
- `retired_cnt`: increments on every `pc_we` cycle and wraps from 2^32-1 to 0. It is not cleared by FAULT or `fault_clr`.

## Timing
- Reset (asynchronous):
  - `state`=IDLE, timer=0, `retired_cnt`=0.
  - Every strobe, `busy` and `fault` = 0; `mem_req` drops in the same cycle.
  - Assertion mid-transfer abandons the transfer with no retirement.
- Zero-wait latencies (FETCH entry to retirement cycle, inclusive):
  - Branch: 3 cycles.
  - ALU/jump/U-type: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds 1.
- Back-to-back: with `run`=1, FETCH of the next instruction is the cycle after retirement.
- `run` deassertion affects only the next start; the current instruction always completes.

## Configuration
- `SEQ_PERF_CNT_EN` defined: `retired_cnt` is a live 32-bit counter.
- `SEQ_PERF_CNT_EN` undefined: `retired_cnt` is tied to 0 and no counter flops exist; the port list is unchanged.

## Test plan
- Reset, `run`=1, `mem_ready`=1, `opcode`=0110011 -> `state` 1,2,3,5; `ir_we` in cycle 1; `rf_we`=`pc_we`=1 in cycle 4; `state`=1 in cycle 5; `retired_cnt`=1.
- Load 0000011 with `mem_ready` low for 3 MEM cycles -> `mem_req`=1, `mem_data_sel`=1, `mem_write`=0 for 4 cycles, then WB; 8 cycles total.
- Store 0100011 -> `mem_write`=1 in MEM; `pc_we` on the ready cycle; `rf_we` never 1; then IDLE if `run`=0.
- `TIMEOUT_CYC`=4 with `mem_ready`=0 in FETCH -> FAULT after 4 FETCH cycles, `mem_req`=0, `fault`=1; `fault_clr` pulse -> IDLE.
- Opcode 1111111 -> FAULT directly after EXEC, `retired_cnt` unchanged. In a separate run, `mem_err` with `mem_ready` both 1 in MEM -> FAULT.
- `reset` asserted mid-MEM -> same cycle: `mem_req`=0, `state`=0, `retired_cnt`=0. Build without `SEQ_PERF_CNT_EN` -> `retired_cnt`=0 after 10 instructions.
